// File: rtl/tdp_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_pipelined
// Description : Single-clock true dual-port RAM with byte-lane writes,
//               1..4 cycle read pipeline, selectable write-port output mode,
//               same-address collision resolution with flag and counter,
//               and a post-reset engine that clears the array.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_pipelined #(
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter int                    WRITE_MODE   = 0,
    parameter int                    PRIORITY     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wea,
    input  logic [ADDR_WIDTH-1:0]            i_addra,
    input  logic [DATA_WIDTH-1:0]            i_dina,
    output logic [DATA_WIDTH-1:0]            o_douta,
    output logic                             o_valida,
    input  logic                             i_enb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_web,
    input  logic [ADDR_WIDTH-1:0]            i_addrb,
    input  logic [DATA_WIDTH-1:0]            i_dinb,
    output logic [DATA_WIDTH-1:0]            o_doutb,
    output logic                             o_validb,
    output logic                             o_ready,
    output logic                             o_collision,
    output logic [15:0]                      o_coll_cnt
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("tdp_ram_pipelined: READ_LATENCY must be 1..4");
        end
        if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
            $error("tdp_ram_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    logic [0:0]            state_q;
    logic [ADDR_WIDTH-1:0] init_addr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  acc_a, acc_b, wr_a, wr_b, same_addr, coll_d;
    logic [DATA_WIDTH-1:0] old_a, old_b, merge_a, merge_b, resolved;
    logic [DATA_WIDTH-1:0] word_a, word_b;
    logic [1:0]            rvld_d;
    logic [DATA_WIDTH-1:0] rdat_d [2];

    // Stage 0..READ_LATENCY per port; the last stage drives the outputs.
    logic                  pvld_q [2][READ_LATENCY+1];
    logic [DATA_WIDTH-1:0] pdat_q [2][READ_LATENCY+1];

    logic                  coll_stage_q, coll_q;
    logic [15:0]           coll_cnt_q;

    assign acc_a     = (state_q == ST_READY) && i_ena;
    assign acc_b     = (state_q == ST_READY) && i_enb;
    assign wr_a      = acc_a && (|i_wea);
    assign wr_b      = acc_b && (|i_web);
    assign same_addr = acc_a && acc_b && (i_addra == i_addrb);
    assign coll_d    = same_addr && (wr_a || wr_b);
    assign old_a     = mem_q[i_addra];
    assign old_b     = mem_q[i_addrb];

    // Lane merge per port, plus the combined word when both ports hit one address.
    always_comb begin
        merge_a  = old_a;
        merge_b  = old_b;
        resolved = old_a;
        for (int k = 0; k < NB; k++) begin
            if (i_wea[k]) merge_a[k*BYTE_WIDTH +: BYTE_WIDTH] = i_dina[k*BYTE_WIDTH +: BYTE_WIDTH];
            if (i_web[k]) merge_b[k*BYTE_WIDTH +: BYTE_WIDTH] = i_dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr_a && i_wea[k] && wr_b && i_web[k]) begin
                resolved[k*BYTE_WIDTH +: BYTE_WIDTH] = (PRIORITY != 0) ?
                    i_dinb[k*BYTE_WIDTH +: BYTE_WIDTH] : i_dina[k*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (wr_a && i_wea[k]) begin
                resolved[k*BYTE_WIDTH +: BYTE_WIDTH] = i_dina[k*BYTE_WIDTH +: BYTE_WIDTH];
            end else if (wr_b && i_web[k]) begin
                resolved[k*BYTE_WIDTH +: BYTE_WIDTH] = i_dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        word_a = same_addr ? resolved : merge_a;
        word_b = same_addr ? resolved : merge_b;
    end

    // Pipeline entry: a reader (or mode-0 writer) sees the pre-edge word, a mode-1 writer the stored word.
    always_comb begin
        rvld_d    = 2'b00;
        rdat_d[0] = old_a;
        rdat_d[1] = old_b;
        if (acc_a) begin
            rvld_d[0] = !(wr_a && (WRITE_MODE == 2));
            if (wr_a && (WRITE_MODE == 1)) rdat_d[0] = word_a;
        end
        if (acc_b) begin
            rvld_d[1] = !(wr_b && (WRITE_MODE == 2));
            if (wr_b && (WRITE_MODE == 1)) rdat_d[1] = word_b;
        end
    end

    // Init/ready state machine: sweep every address once after reset release.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_addr_q <= init_addr_q + 1'b1;
            if (init_addr_q == {ADDR_WIDTH{1'b1}}) state_q <= ST_READY;
        end
    end

    // Array writes; one write suffices when both ports target the same word.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (state_q == ST_INIT) begin
                mem_q[init_addr_q] <= INIT_VALUE;
            end else begin
                if (wr_a) mem_q[i_addra] <= word_a;
                if (wr_b && !(same_addr && wr_a)) mem_q[i_addrb] <= word_b;
            end
        end
    end

    // Read pipelines; data registers only load on a valid so the output holds otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i <= READ_LATENCY; i++) begin
                    pvld_q[p][i] <= 1'b0;
                    pdat_q[p][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                pvld_q[p][0] <= rvld_d[p];
                if (rvld_d[p]) pdat_q[p][0] <= rdat_d[p];
                for (int i = 1; i <= READ_LATENCY; i++) begin
                    pvld_q[p][i] <= pvld_q[p][i-1];
                    if (pvld_q[p][i-1]) pdat_q[p][i] <= pdat_q[p][i-1];
                end
            end
        end
    end

    // Collision flag lags the accept by one edge; counter steps with the flag and saturates.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            coll_stage_q <= 1'b0;
            coll_q       <= 1'b0;
            coll_cnt_q   <= '0;
        end else begin
            coll_stage_q <= coll_d;
            coll_q       <= coll_stage_q;
            if (coll_stage_q && (coll_cnt_q != 16'hFFFF)) coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign o_douta     = pdat_q[0][READ_LATENCY];
    assign o_valida    = pvld_q[0][READ_LATENCY];
    assign o_doutb     = pdat_q[1][READ_LATENCY];
    assign o_validb    = pvld_q[1][READ_LATENCY];
    assign o_ready     = (state_q == ST_READY);
    assign o_collision = coll_q;
    assign o_coll_cnt  = coll_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdp_ram_pipelined
// Description : Directed self-checking bench for tdp_ram_pipelined using three
//               instances (8-bit read-first, 16-bit write-first, 8-bit
//               no-change with 3-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // dut0: 8-bit, latency 1, read-first, INIT 0x5A
    logic       rst0_n, ena0, enb0, valida0, validb0, ready0, coll0;
    logic [0:0] wea0, web0;
    logic [3:0] addra0, addrb0;
    logic [7:0] dina0, dinb0, douta0, doutb0;
    logic [15:0] cnt0;
    // dut1: 16-bit, latency 1, write-first, PRIORITY A
    logic        rst1_n, ena1, enb1, valida1, validb1, ready1, coll1;
    logic [1:0]  wea1, web1;
    logic [3:0]  addra1, addrb1;
    logic [15:0] dina1, dinb1, douta1, doutb1;
    logic [15:0] cnt1;
    // dut2: 8-bit, latency 3, no-change
    logic       rst2_n, ena2, enb2, valida2, validb2, ready2, coll2;
    logic [0:0] wea2, web2;
    logic [3:0] addra2, addrb2;
    logic [7:0] dina2, dinb2, douta2, doutb2;
    logic [15:0] cnt2;

    tdp_ram_pipelined #(.INIT_VALUE(8'h5A)) dut0 (
        .i_clk(clk), .i_rst_n(rst0_n),
        .i_ena(ena0), .i_wea(wea0), .i_addra(addra0), .i_dina(dina0), .o_douta(douta0), .o_valida(valida0),
        .i_enb(enb0), .i_web(web0), .i_addrb(addrb0), .i_dinb(dinb0), .o_doutb(doutb0), .o_validb(validb0),
        .o_ready(ready0), .o_collision(coll0), .o_coll_cnt(cnt0));

    tdp_ram_pipelined #(.DATA_WIDTH(16), .WRITE_MODE(1), .PRIORITY(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst1_n),
        .i_ena(ena1), .i_wea(wea1), .i_addra(addra1), .i_dina(dina1), .o_douta(douta1), .o_valida(valida1),
        .i_enb(enb1), .i_web(web1), .i_addrb(addrb1), .i_dinb(dinb1), .o_doutb(doutb1), .o_validb(validb1),
        .o_ready(ready1), .o_collision(coll1), .o_coll_cnt(cnt1));

    tdp_ram_pipelined #(.READ_LATENCY(3), .WRITE_MODE(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n),
        .i_ena(ena2), .i_wea(wea2), .i_addra(addra2), .i_dina(dina2), .o_douta(douta2), .o_valida(valida2),
        .i_enb(enb2), .i_web(web2), .i_addrb(addrb2), .i_dinb(dinb2), .o_doutb(doutb2), .o_validb(validb2),
        .o_ready(ready2), .o_collision(coll2), .o_coll_cnt(cnt2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0_n = 0; ena0 = 0; enb0 = 0; wea0 = 0; web0 = 0; addra0 = 0; addrb0 = 0; dina0 = 0; dinb0 = 0;
        rst1_n = 0; ena1 = 0; enb1 = 0; wea1 = 0; web1 = 0; addra1 = 0; addrb1 = 0; dina1 = 0; dinb1 = 0;
        rst2_n = 0; ena2 = 0; enb2 = 0; wea2 = 0; web2 = 0; addra2 = 0; addrb2 = 0; dina2 = 0; dinb2 = 0;
        tick; tick;
        check("rst_ready", ready0, 0);
        check("rst_valida", valida0, 0);
        check("rst_douta", douta0, 0);
        check("rst_coll", coll0, 0);
        check("rst_cnt", cnt0, 0);

        // ---- Init: requests during INIT (including a would-be collision) are ignored
        rst0_n = 1; rst1_n = 1; rst2_n = 1;
        ena0 = 1; wea0 = 1; addra0 = 0; dina0 = 8'hFF;
        enb0 = 1; web0 = 1; addrb0 = 0; dinb0 = 8'hEE;
        for (int k = 1; k <= 16; k++) begin
            tick;
            check("init_valida", valida0, 0);
            check("init_validb", validb0, 0);
            check("init_coll", coll0, 0);
            check("init_ready", ready0, (k == 16));
        end
        check("init_ready1", ready1, 1);
        check("init_ready2", ready2, 1);
        ena0 = 0; enb0 = 0; wea0 = 0; web0 = 0;
        tick;
        check("init_post_valid", valida0, 0);
        check("init_post_cnt", cnt0, 0);

        // Back-to-back reads of the whole array
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin ena0 = 1; addra0 = 4'(i); end
            else ena0 = 0;
            tick;
            if (i > 0) begin
                check("sweep_valid", valida0, 1);
                check("sweep_data", douta0, 8'h5A);
            end
        end
        tick;
        check("sweep_end_valid", valida0, 0);
        check("sweep_hold", douta0, 8'h5A);

        // ---- Cross-port write then read
        ena0 = 1; wea0 = 1; addra0 = 3; dina0 = 8'hA5;
        tick;
        ena0 = 0; wea0 = 0; enb0 = 1; web0 = 0; addrb0 = 3;
        tick;
        check("wr_mode0_valid", valida0, 1);
        check("wr_mode0_old", douta0, 8'h5A);
        enb0 = 0;
        tick;
        check("xport_validb", validb0, 1);
        check("xport_doutb", doutb0, 8'hA5);
        check("xport_valida_low", valida0, 0);
        ena0 = 1; addra0 = 3;
        tick;
        addra0 = 4;
        tick;
        check("b2b_v0", valida0, 1);
        check("b2b_d0", douta0, 8'hA5);
        ena0 = 0;
        tick;
        check("b2b_v1", valida0, 1);
        check("b2b_d1", douta0, 8'h5A);
        tick;
        check("b2b_end", valida0, 0);

        // ---- Read/write collision
        ena0 = 1; wea0 = 1; addra0 = 5; dina0 = 8'h3C;
        tick;
        dina0 = 8'h55; enb0 = 1; web0 = 0; addrb0 = 5;
        tick;
        check("rw_coll_early", coll0, 0);
        ena0 = 0; wea0 = 0; enb0 = 0;
        tick;
        check("rw_coll_doutb", doutb0, 8'h3C);
        check("rw_coll_validb", validb0, 1);
        check("rw_coll_douta", douta0, 8'h3C);
        check("rw_coll_flag", coll0, 1);
        check("rw_coll_cnt", cnt0, 1);
        tick;
        check("rw_coll_flag_off", coll0, 0);
        check("rw_coll_cnt_hold", cnt0, 1);
        enb0 = 1; addrb0 = 5;
        tick;
        enb0 = 0;
        tick;
        check("rw_after_read", doutb0, 8'h55);
        // Both ports reading the same word is not a collision
        ena0 = 1; addra0 = 5; enb0 = 1; addrb0 = 5;
        tick;
        ena0 = 0; enb0 = 0;
        tick;
        check("rr_douta", douta0, 8'h55);
        check("rr_doutb", doutb0, 8'h55);
        check("rr_no_coll", coll0, 0);
        tick;
        check("rr_cnt", cnt0, 1);
        // Independent writes to different addresses, then swapped reads
        ena0 = 1; wea0 = 1; addra0 = 8; dina0 = 8'h81;
        enb0 = 1; web0 = 1; addrb0 = 9; dinb0 = 8'h92;
        tick;
        wea0 = 0; web0 = 0; addra0 = 9; addrb0 = 8;
        tick;
        ena0 = 0; enb0 = 0;
        tick;
        check("indep_a", douta0, 8'h92);
        check("indep_b", doutb0, 8'h81);
        check("indep_no_coll", coll0, 0);

        // ---- dut1: write/write collision with byte lanes, write-first outputs
        ena1 = 1; wea1 = 2'b01; addra1 = 7; dina1 = 16'h1111;
        enb1 = 1; web1 = 2'b11; addrb1 = 7; dinb1 = 16'h2222;
        tick;
        ena1 = 0; enb1 = 0; wea1 = 0; web1 = 0;
        tick;
        check("ww_douta", douta1, 16'h2211);
        check("ww_doutb", doutb1, 16'h2211);
        check("ww_validb", validb1, 1);
        check("ww_flag", coll1, 1);
        check("ww_cnt", cnt1, 1);
        tick;
        check("ww_flag_off", coll1, 0);
        ena1 = 1; addra1 = 7;
        tick;
        ena1 = 0;
        tick;
        check("ww_readback", douta1, 16'h2211);
        // Write-first sweep at address 2
        ena1 = 1; wea1 = 2'b11; addra1 = 2; dina1 = 16'h0010;
        tick;
        dina1 = 16'h0077;
        tick;
        check("wf_first", douta1, 16'h0010);
        wea1 = 2'b10; dina1 = 16'hAB00;
        tick;
        check("wf_second", douta1, 16'h0077);
        ena1 = 0; wea1 = 0;
        tick;
        check("wf_lane_merge", douta1, 16'hAB77);
        // Reader sees pre-write word even in write-first mode
        ena1 = 1; wea1 = 0; addra1 = 2;
        enb1 = 1; web1 = 2'b11; addrb1 = 2; dinb1 = 16'hCDEF;
        tick;
        ena1 = 0; enb1 = 0; web1 = 0;
        tick;
        check("wf_rw_reader", douta1, 16'hAB77);
        check("wf_rw_writer", doutb1, 16'hCDEF);
        tick;
        check("wf_rw_cnt", cnt1, 2);

        // ---- dut2: no-change writes, latency 3
        ena2 = 1; wea2 = 1; addra2 = 2; dina2 = 8'h10;
        tick;
        ena2 = 0; wea2 = 0;
        for (int k = 0; k < 4; k++) begin tick; check("nc_no_valid", valida2, 0); end
        ena2 = 1; addra2 = 2;
        tick;
        ena2 = 0;
        tick; tick;
        check("lat3_early", valida2, 0);
        tick;
        check("lat3_valid", valida2, 1);
        check("lat3_data", douta2, 8'h10);
        ena2 = 1; wea2 = 1; dina2 = 8'h77;
        tick;
        ena2 = 0; wea2 = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("nc_valid", valida2, 0);
            check("nc_hold", douta2, 8'h10);
        end
        ena2 = 1; wea2 = 1; addra2 = 0; dina2 = 8'h0A;
        tick;
        addra2 = 1; dina2 = 8'h0B;
        tick;
        wea2 = 0; addra2 = 0;
        tick;
        addra2 = 1;
        tick;
        addra2 = 2;
        tick;
        ena2 = 0;
        check("pipe_early", valida2, 0);
        tick;
        check("pipe_v0", valida2, 1);
        check("pipe_d0", douta2, 8'h0A);
        tick;
        check("pipe_v1", valida2, 1);
        check("pipe_d1", douta2, 8'h0B);
        tick;
        check("pipe_v2", valida2, 1);
        check("pipe_d2", douta2, 8'h77);
        tick;
        check("pipe_end", valida2, 0);
        check("pipe_hold", douta2, 8'h77);

        // Collision to make the counter non-zero, then reset mid-stream
        ena2 = 1; wea2 = 1; addra2 = 9; dina2 = 8'h99;
        enb2 = 1; web2 = 0; addrb2 = 9;
        tick;
        ena2 = 0; wea2 = 0; enb2 = 0;
        tick;
        check("d2_coll", coll2, 1);
        check("d2_cnt", cnt2, 1);
        ena2 = 1; addra2 = 0;
        tick;
        addra2 = 1;
        tick;
        rst2_n = 0; ena2 = 0;
        tick;
        check("mrst_valid", valida2, 0);
        check("mrst_douta", douta2, 0);
        check("mrst_cnt", cnt2, 0);
        check("mrst_coll", coll2, 0);
        check("mrst_ready", ready2, 0);
        rst2_n = 1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            check("reinit_valid", valida2, 0);
            check("reinit_ready", ready2, (k == 16));
        end
        ena2 = 1; addra2 = 2;
        tick;
        ena2 = 0;
        tick; tick; tick;
        check("reinit_rd_valid", valida2, 1);
        check("reinit_rd_data", douta2, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdp_ram_pipelined.md
Name: tdp_ram_pipelined

Overview:
Single-clock true dual-port RAM. It is the parametrised successor of the team's dual_port_ram, adding:
- per-port byte-lane write enables
- configurable read latency of 1..4 cycles
- selectable write-port output mode
- defined same-address collision resolution, with a collision flag and counter
- a post-reset initialisation engine that clears the array before accesses are accepted

It sits between two independent masters (e.g. a DMA and a CPU-side requester) sharing one buffer.

Parameters:
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH; every address is valid.
- DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, accept-to-output cycles, 1..4; any other value is an elaboration error.
- WRITE_MODE, 0, output behaviour of a writing port: 0 read-first (old word), 1 write-first (merged new word), 2 no-change (no output).
- PRIORITY, 0, winning port on overlapping write lanes: 0 = A, 1 = B.
- INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the init engine.

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_ena  in  1  port A access request
- i_wea  in  NB  port A byte write enables; all-zero = read
- i_addra  in  ADDR_WIDTH  port A address
- i_dina  in  DATA_WIDTH  port A write data
- o_douta  out  DATA_WIDTH  port A read data
- o_valida  out  1  o_douta valid, one-cycle pulse per qualifying access
- i_enb, i_web, i_addrb, i_dinb, o_doutb, o_validb  same as port A, for port B
- o_ready  out  1  init done; accesses accepted
- o_collision  out  1  one-cycle pulse per collision
- o_coll_cnt  out  16  saturating collision count

Behaviour:
- Reset, sampled at posedge with i_rst_n=0:
  - FSM -> INIT, init address -> 0.
  - o_ready, o_douta, o_doutb, o_valida, o_validb, o_collision, o_coll_cnt -> 0.
  - Read pipelines flushed; pending valids dropped.
  - Array contents are not reset directly.
- FSM INIT:
  - The first posedge with i_rst_n=1 writes INIT_VALUE to address 0; each later posedge writes the next address.
  - After DEPTH writes, FSM -> READY and o_ready=1. o_ready rises on the DEPTH-th posedge after release.
  - Port inputs are ignored in INIT: no writes, no valids, no collisions.
- FSM READY: stays in READY until reset. Reset asserted mid-INIT restarts INIT from address 0.
- Accept: at a posedge with o_ready=1 and i_enX=1.
  - Any i_weX bit set = write. Lane k (bits k*BYTE_WIDTH+:BYTE_WIDTH) is updated where i_weX[k]=1; other lanes are untouched.
  - Otherwise = read.
- Read latency:
  - Read data appears on o_doutX with o_validX=1 exactly READ_LATENCY posedges after the accept edge.
  - Fully pipelined: one access per port per cycle, back-to-back.
- Write output per WRITE_MODE:
  - 0: old word with valid, same latency as a read.
  - 1: merged new word with valid, same latency.
  - 2: no valid; o_doutX holds.
- Output hold: o_doutX holds its last value whenever o_validX=0.
- Collision: both ports accepted, same address, and at least one writing.
  - Both write: non-overlapping lanes take their own port's data; overlapping lanes take the PRIORITY port's data.
  - WRITE_MODE=1 output on both ports in a write/write collision: the final resolved word.
  - One writes, one reads: the reading port returns the pre-write word regardless of WRITE_MODE. The write completes normally.
  - Both read: not a collision.
  - o_collision is registered: high on the posedge after the colliding accept, for one cycle.
  - o_coll_cnt increments on the same edge and saturates at 0xFFFF.
- Different addresses on A and B are fully independent in the same cycle.

Test Plan:
1. Init: defaults, INIT_VALUE=0x5A. Hold i_rst_n=0 for 2 cycles, release -> o_ready rises 16 cycles later; reading addresses 0..15 returns 0x5A each, o_valida pulsed 1 cycle after each accept. Requests issued during INIT produce no valid and no write.
2. Basic cross-port: A writes 0xA5 to addr 3, B reads addr 3 next cycle -> o_doutb=0xA5, o_validb high 1 cycle later. Back-to-back A reads of addr 3,4 -> two consecutive valid cycles.
3. Write/write collision: DATA_WIDTH=16, PRIORITY=0, addr 7. A writes we=01 data 0x1111; B writes we=11 data 0x2222 -> later read gives 0x2211. o_collision high for exactly one cycle; o_coll_cnt=1.
4. Read/write collision: mem[5]=0x3C. A writes 0x55 to 5 while B reads 5 -> o_doutb=0x3C, o_collision pulses. A subsequent read of 5 returns 0x55.
5. WRITE_MODE sweep: addr 2 holds 0x10, A writes 0x77:
   - mode 0 -> o_douta=0x10 valid
   - mode 1 -> 0x77 valid
   - mode 2 -> o_valida stays 0, o_douta unchanged
6. Latency and reset: READ_LATENCY=3, A reads addr 0,1,2 on consecutive cycles -> valids on 3 consecutive cycles starting 3 edges after the first accept. Repeat with i_rst_n pulsed low after the second accept -> no further valids, outputs 0, o_coll_cnt=0, o_ready low until INIT completes again.
